// File: rtl/adder_seq_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial add/subtract sequencer.
// The master drives operands and accepts results; the slave is the sequencer.
interface adder_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract: one 4-bit adder reused LSB nibble first,
// with the inter-nibble carry held in a register between cycles.
module full_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  adder_seq_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [3:0]       slice_sum;
  logic             slice_carry;

  full_adder4 u_fa (
    .a     (a_reg[{idx_reg, 2'b00} +: 4]),
    .b     (b_reg[{idx_reg, 2'b00} +: 4]),
    .c_in  (carry_reg),
    .sum   (slice_sum),
    .c_out (slice_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction is a + ~b + 1, so invert b and force the first carry.
            a_reg        <= bus.a;
            b_reg        <= bus.sub ? ~bus.b : bus.b;
            carry_reg    <= bus.sub ? 1'b1 : bus.c_in;
            idx_reg      <= '0;
            result_reg   <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          result_reg[{idx_reg, 2'b00} +: 4] <= slice_sum;
          carry_reg                         <= slice_carry;
          if (idx_reg == LAST_IDX) begin
            // Wrap instead of running past the last nibble so the adder
            // inputs never select outside the operand while parked in DONE.
            idx_reg       <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = result_reg;
  assign bus.c_out     = carry_reg;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: WIDTH=16 instance under directed and
// random traffic, plus a WIDTH=4 instance for single-nibble latency/throughput.
module tb_adder_seq_ctrl;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_seq_ctrl_if #(.WIDTH(W)) bus ();
  adder_seq_ctrl_if #(.WIDTH(4)) bus4 ();

  adder_seq_ctrl #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  adder_seq_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus4.out_ready = 1'b1;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    int           acc_cyc;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   bp_mode = 0;
  int   op_id   = 0;

  always @(posedge clk) cyc++;

  // out_ready changes just after the active edge so it is settled at the monitor.
  always @(posedge clk) begin
    #2;
    case (bp_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic, c_out is bit WIDTH of the wide result.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W:0] r;
    if (sub) r = {1'b0, a} + {1'b1, {W{1'b0}}} - {1'b0, b};
    else     r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return r;
  endfunction

  logic         prev_valid = 1'b0;
  logic         prev_hs    = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_c;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      check("in_ready_vs_inflight", bus.in_ready, (sb.size() == 0));
      if (sb.size() == 0) check("out_valid_when_idle", bus.out_valid, 0);
      if (bus.out_valid && sb.size() > 0) begin
        if (!prev_valid) check("latency", cyc - sb[0].acc_cyc, NIB);
        else if (!prev_hs) begin
          check("hold_sum", bus.sum, prev_sum);
          check("hold_c_out", bus.c_out, prev_c);
        end
        prev_sum = bus.sum;
        prev_c   = bus.c_out;
        if (bus.out_ready) begin
          exp_t e;
          e = sb.pop_front();
          check("sum", bus.sum, e.sum);
          check("c_out", bus.c_out, e.c_out);
          $display("op %0d: sum=%h c_out=%b expected sum=%h c_out=%b",
                   e.id, bus.sum, bus.c_out, e.sum, e.c_out);
        end
        prev_hs = bus.out_ready;
      end else begin
        prev_hs = 1'b0;
      end
      prev_valid = bus.out_valid;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int   n;
    exp_t e;
    logic [W:0] r;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: in_ready low for %0d cycles, required 1", n);
        return;
      end
    end
    bus.a = a; bus.b = b; bus.c_in = cin; bus.sub = sub; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    r         = model(a, b, cin, sub);
    e.sum     = r[W-1:0];
    e.c_out   = r[W];
    e.acc_cyc = cyc;
    e.id      = op_id++;
    sb.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    int last;
    int hits;
    int start;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c_in = 1'b0; bus4.sub = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_c_out", bus.c_out, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h0FFF, 16'h0000, 1'b1, 1'b0);
    issue(16'h0007, 16'h0005, 1'b1, 1'b1);
    issue(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_drain();

    // Backpressure in DONE while new commands are offered.
    bp_mode = 1;
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_reached_done", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      bus.a = W'($urandom); bus.b = W'($urandom); bus.in_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bp_mode = 0;
    wait_drain();
    issue(16'h00F0, 16'h0F0F, 1'b1, 1'b0);
    wait_drain();

    // Asynchronous reset two RUN edges into an op.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_sum", bus.sum, 0);
    check("arst_c_out", bus.c_out, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_drain();

    bp_mode = 2;
    for (int i = 0; i < 40; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_drain();
    bp_mode = 0;

    // Single-nibble build, commands held valid, consumer always ready.
    @(negedge clk);
    bus4.a = 4'h9; bus4.b = 4'h8; bus4.c_in = 1'b1; bus4.sub = 1'b0; bus4.in_valid = 1'b1;
    start = cyc;
    last  = -1;
    hits  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus4.out_valid) begin
        hits++;
        check("w4_sum", bus4.sum, 4'h2);
        check("w4_c_out", bus4.c_out, 1);
        check("w4_in_ready", bus4.in_ready, 0);
        if (last < 0) check("w4_latency", cyc - (start + 1), 1);
        else          check("w4_spacing", cyc - last, 3);
        $display("w4 op %0d: sum=%h c_out=%b at cycle %0d", hits, bus4.sum, bus4.c_out, cyc);
        last = cyc;
      end
    end
    check("w4_result_count", hits, 4);
    bus4.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
